sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared definitions for the SRAM arbiter. Holds the response
//               state encoding and the requester identifiers used by the
//               round-robin grant logic.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    // Response state: which requester (if any) sees data_ok this cycle.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } state_e;

    // Requester identifiers, stored in the last-grant register.
    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

endpackage : sram_arbiter_pkg
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-master arbiter (instruction fetch and load/store) in front
//               of a single-port synchronous SRAM. One access per cycle, fixed
//               one-cycle addr_ok -> data_ok latency, round-robin on conflict.
// Ports       : clk, resetn            - clock, async active-low reset
//               inst_req/addr          - fetch request in
//               inst_addr_ok/data_ok   - fetch handshake out, inst_rdata
//               data_req/we/addr/wdata - load/store request in
//               data_addr_ok/data_ok   - load/store handshake out, data_rdata
//               sram_en/we/addr/wdata  - SRAM access out
//               sram_rdata             - SRAM read data (one cycle after en)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e r_state_q;
    state_e w_state_d;
    logic   r_last_grant_q;
    logic   w_last_grant_d;
    // Cleared by reset and set on the first clock edge afterwards, so the
    // edge that ends the release cycle cannot accept a request.
    logic   r_ready_q;
    logic   w_ready_d;

    logic   w_grant_inst;
    logic   w_grant_data;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q      <= IDLE;
            r_last_grant_q <= REQ_INST;
            r_ready_q      <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_ready_q      <= w_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick, grant mux and response FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready_d      = 1'b1;
        w_grant_inst   = 1'b0;
        w_grant_data   = 1'b0;
        w_state_d      = IDLE;
        w_last_grant_d = r_last_grant_q;

        sram_we        = 1'b0;
        sram_addr      = '0;
        sram_wdata     = '0;

        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
        data_data_ok   = 1'b0;
        data_rdata     = '0;

        // On conflict the side that did not win last time goes first.
        if (r_ready_q) begin
            if (inst_req && data_req) begin
                w_grant_data = (r_last_grant_q == REQ_INST);
                w_grant_inst = (r_last_grant_q == REQ_DATA);
            end else begin
                w_grant_inst = inst_req;
                w_grant_data = data_req;
            end
        end

        if (w_grant_data) begin
            sram_we        = data_we;
            sram_addr      = data_addr;
            sram_wdata     = data_wdata;
            w_state_d      = RESP_DATA;
            w_last_grant_d = REQ_DATA;
        end else if (w_grant_inst) begin
            sram_addr      = inst_addr;
            w_state_d      = RESP_INST;
            w_last_grant_d = REQ_INST;
        end

        // Response side depends only on the registered state, so a new grant
        // can overlap the current response.
        case (r_state_q)
            RESP_INST: begin
                inst_data_ok = 1'b1;
                inst_rdata   = sram_rdata;
            end
            RESP_DATA: begin
                data_data_ok = 1'b1;
                data_rdata   = sram_rdata;
            end
            default: ;
        endcase
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign sram_en      = w_grant_inst | w_grant_data;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter. A behavioural
//               synchronous SRAM returns stored words, or the bitwise inverse
//               of the address for locations never written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              resetn;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    sram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: read data appears one cycle after the strobe.
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    initial sram_rdata = '0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] = sram_wdata;
            end else if (mem.exists(sram_addr)) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                sram_rdata <= ~sram_addr;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'h1C00_0010;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'h0;

        // In reset with both requests up: nothing may be accepted.
        @(negedge clk);
        check_eq("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check_eq("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check_eq("rst_sram_en",      32'(sram_en),      32'd0);
        check_eq("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check_eq("rst_data_data_ok", 32'(data_data_ok), 32'd0);

        // Release between edges: still no grant until an edge has passed.
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rel_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check_eq("rel_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check_eq("rel_sram_en",      32'(sram_en),      32'd0);

        // Conflict after reset: data first, then inst.
        next_cycle();
        @(negedge clk);
        check_eq("c1_data_addr_ok", 32'(data_addr_ok), 32'd1);
        check_eq("c1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check_eq("c1_sram_en",      32'(sram_en),      32'd1);
        check_eq("c1_sram_addr",    sram_addr,         32'h0000_0200);
        check_eq("c1_sram_we",      32'(sram_we),      32'd0);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check_eq("c2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check_eq("c2_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check_eq("c2_sram_addr",    sram_addr,         32'h1C00_0010);
        check_eq("c2_data_data_ok", 32'(data_data_ok), 32'd1);
        check_eq("c2_data_rdata",   data_rdata,        32'hFFFF_FDFF);
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        check_eq("c3_inst_data_ok", 32'(inst_data_ok), 32'd1);
        check_eq("c3_inst_rdata",   inst_rdata,        32'hE3FF_FFEF);
        check_eq("c3_data_data_ok", 32'(data_data_ok), 32'd0);
        check_eq("c3_sram_en",      32'(sram_en),      32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("idle_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check_eq("idle_inst_rdata",   inst_rdata,        32'd0);
        check_eq("idle_data_rdata",   data_rdata,        32'd0);

        // Store then load of the same word.
        next_cycle();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_0100;
        data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("st_data_addr_ok", 32'(data_addr_ok), 32'd1);
        check_eq("st_sram_we",      32'(sram_we),      32'd1);
        check_eq("st_sram_addr",    sram_addr,         32'h0000_0100);
        check_eq("st_sram_wdata",   sram_wdata,        32'hDEAD_BEEF);
        next_cycle();
        data_we = 1'b0;
        @(negedge clk);
        check_eq("ld_data_data_ok", 32'(data_data_ok), 32'd1);
        check_eq("ld_data_addr_ok", 32'(data_addr_ok), 32'd1);
        check_eq("ld_sram_we",      32'(sram_we),      32'd0);

        // Lone fetch issued in the load's response cycle.
        next_cycle();
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        check_eq("ld_rdata",         data_rdata,        32'hDEAD_BEEF);
        check_eq("ld_rsp_data_ok",   32'(data_data_ok), 32'd1);
        check_eq("lf_inst_addr_ok",  32'(inst_addr_ok), 32'd1);
        check_eq("lf_sram_en",       32'(sram_en),      32'd1);
        check_eq("lf_sram_addr",     sram_addr,         32'h1C00_0000);

        // Sustained conflict: D,I,D,I,D,I with one access every cycle.
        next_cycle();
        inst_addr = 32'h1C00_0008;
        data_req  = 1'b1;
        data_addr = 32'h0000_0300;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rr_data_addr_ok", 32'(data_addr_ok), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_inst_addr_ok", 32'(inst_addr_ok), (i % 2 == 0) ? 32'd0 : 32'd1);
            check_eq("rr_sram_en",      32'(sram_en),      32'd1);
            check_eq("rr_inst_data_ok", 32'(inst_data_ok), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_data_data_ok", 32'(data_data_ok), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) begin
                check_eq("rr_inst_rdata", inst_rdata, (i == 0) ? 32'hE3FF_FFFF : 32'hE3FF_FFF7);
            end else begin
                check_eq("rr_data_rdata", data_rdata, 32'hFFFF_FCFF);
            end
            next_cycle();
        end

        // Lone load, then reset while its response is on the bus.
        inst_req  = 1'b0;
        data_addr = 32'h0000_0400;
        @(negedge clk);
        check_eq("pre_data_addr_ok", 32'(data_addr_ok), 32'd1);
        next_cycle();
        data_req = 1'b0;
        check_eq("pre_data_data_ok", 32'(data_data_ok), 32'd1);
        check_eq("pre_data_rdata",   data_rdata,        32'hFFFF_FBFF);
        resetn = 1'b0;
        #1;
        check_eq("ar_data_data_ok", 32'(data_data_ok), 32'd0);
        check_eq("ar_data_rdata",   data_rdata,        32'd0);
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_000C;
        data_req  = 1'b1;
        data_addr = 32'h0000_0500;
        next_cycle();
        @(negedge clk);
        check_eq("ar_hold_addr_ok", 32'(data_addr_ok | inst_addr_ok), 32'd0);
        check_eq("ar_hold_data_ok", 32'(data_data_ok | inst_data_ok), 32'd0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("ar_rel_data_ok", 32'(data_data_ok), 32'd0);
        check_eq("ar_rel_addr_ok", 32'(data_addr_ok | inst_addr_ok), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("ar_c1_data_addr_ok", 32'(data_addr_ok), 32'd1);
        check_eq("ar_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check_eq("ar_c1_data_data_ok", 32'(data_data_ok), 32'd0);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check_eq("ar_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check_eq("ar_c2_data_data_ok", 32'(data_data_ok), 32'd1);
        check_eq("ar_c2_data_rdata",   data_rdata,        32'hFFFF_FAFF);
        next_cycle();
        inst_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
